// File: rtl/regfile_scoreboard_pkg.sv
// +----------------------------------------------------------------------+
// | regfile_scoreboard_pkg: shared widths, types and FSM states          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package regfile_scoreboard_pkg;

  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = $clog2(NUM_REGS);

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]   word_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/regfile_scoreboard_bypass_read.sv
// +----------------------------------------------------------------------+
// | regfile_bypass_read: one source operand with write-port forwarding   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module regfile_bypass_read
  import regfile_scoreboard_pkg::*;
(
  input  word_t     stored_i,
  input  reg_addr_t addr_i,
  input  logic      wr_en_i,
  input  reg_addr_t wr_addr_i,
  input  word_t     wr_data_i,
  output word_t     data_o
);

  always_comb begin
    data_o = stored_i;
    if (addr_i == '0) begin
      data_o = '0;
    end else if (wr_en_i && (wr_addr_i == addr_i)) begin
      data_o = wr_data_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// +----------------------------------------------------------------------+
// | regfile_scoreboard: register file with pending scoreboard and a      |
// | two-state operand read FSM. Rev 1.0                                  |
// +----------------------------------------------------------------------+
`default_nettype none

module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_wr_en,
  input  logic [ADDR_W-1:0] reg_wr_addr,
  input  logic [XLEN-1:0]   reg_wr_data,
  input  logic              mark_en,
  input  logic [ADDR_W-1:0] mark_addr,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic              rd_busy,
  output logic              rd_valid,
  output logic [XLEN-1:0]   rs1_data,
  output logic [XLEN-1:0]   rs2_data
);

  word_t               regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] pend_q, pend_d;
  state_e              state_q, state_d;
  reg_addr_t           rs1_lat_q, rs1_lat_d, rs2_lat_q, rs2_lat_d;
  logic                valid_q, valid_d;
  word_t               rs1_q, rs1_d, rs2_q, rs2_d;

  logic      wr_hit;
  reg_addr_t src1_addr, src2_addr;
  logic      src1_pend, src2_pend;
  word_t     src1_byp, src2_byp;

  assign wr_hit = rd_wr_en && (reg_wr_addr != '0);

  // IDLE looks at the live request; WAIT keeps re-checking the held one.
  assign src1_addr = (state_q == ST_IDLE) ? rs1_addr : rs1_lat_q;
  assign src2_addr = (state_q == ST_IDLE) ? rs2_addr : rs2_lat_q;

  assign src1_pend = pend_q[src1_addr] && !(wr_hit && (reg_wr_addr == src1_addr));
  assign src2_pend = pend_q[src2_addr] && !(wr_hit && (reg_wr_addr == src2_addr));

  regfile_bypass_read u_byp_rs1 (
    .stored_i  (regs_q[src1_addr]),
    .addr_i    (src1_addr),
    .wr_en_i   (rd_wr_en),
    .wr_addr_i (reg_wr_addr),
    .wr_data_i (reg_wr_data),
    .data_o    (src1_byp)
  );

  regfile_bypass_read u_byp_rs2 (
    .stored_i  (regs_q[src2_addr]),
    .addr_i    (src2_addr),
    .wr_en_i   (rd_wr_en),
    .wr_addr_i (reg_wr_addr),
    .wr_data_i (reg_wr_data),
    .data_o    (src2_byp)
  );

  // A reservation applied after the clear lets a same-cycle mark win.
  always_comb begin
    pend_d = pend_q;
    if (wr_hit) begin
      pend_d[reg_wr_addr] = 1'b0;
    end
    if (mark_en && (mark_addr != '0)) begin
      pend_d[mark_addr] = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    rs1_lat_d = rs1_lat_q;
    rs2_lat_d = rs2_lat_q;
    valid_d   = 1'b0;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    case (state_q)
      ST_IDLE: begin
        if (rd_req) begin
          rs1_lat_d = rs1_addr;
          rs2_lat_d = rs2_addr;
          if (!src1_pend && !src2_pend) begin
            valid_d = 1'b1;
            rs1_d   = src1_byp;
            rs2_d   = src2_byp;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!src1_pend && !src2_pend) begin
          valid_d = 1'b1;
          rs1_d   = src1_byp;
          rs2_d   = src2_byp;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      pend_q    <= '0;
      state_q   <= ST_IDLE;
      rs1_lat_q <= '0;
      rs2_lat_q <= '0;
      valid_q   <= 1'b0;
      rs1_q     <= '0;
      rs2_q     <= '0;
    end else begin
      if (wr_hit) begin
        regs_q[reg_wr_addr] <= reg_wr_data;
      end
      pend_q    <= pend_d;
      state_q   <= state_d;
      rs1_lat_q <= rs1_lat_d;
      rs2_lat_q <= rs2_lat_d;
      valid_q   <= valid_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
    end
  end

  assign rd_busy  = (state_q == ST_WAIT);
  assign rd_valid = valid_q;
  assign rs1_data = rs1_q;
  assign rs2_data = rs2_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
// +----------------------------------------------------------------------+
// | tb_regfile_scoreboard: vector table plus expected-operand queue      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_wr_en;
  logic [4:0]  reg_wr_addr;
  logic [31:0] reg_wr_data;
  logic        mark_en;
  logic [4:0]  mark_addr;
  logic        rd_req;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        rd_busy;
  logic        rd_valid;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;

  regfile_scoreboard dut (
    .clk         (clk),
    .reset       (reset),
    .rd_wr_en    (rd_wr_en),
    .reg_wr_addr (reg_wr_addr),
    .reg_wr_data (reg_wr_data),
    .mark_en     (mark_en),
    .mark_addr   (mark_addr),
    .rd_req      (rd_req),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rd_busy     (rd_busy),
    .rd_valid    (rd_valid),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        me;
    logic [4:0]  ma;
    logic        rq;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        ev;
    logic        eb;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  typedef struct {
    logic [31:0] d1;
    logic [31:0] d2;
  } exp_t;

  vec_t        vecs[$];
  exp_t        expq[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] last1    = '0;
  logic [31:0] last2    = '0;

  function automatic vec_t v(logic we, logic [4:0] wa, logic [31:0] wd,
                             logic me, logic [4:0] ma,
                             logic rq, logic [4:0] r1, logic [4:0] r2,
                             logic ev, logic eb, logic [31:0] e1, logic [31:0] e2);
    vec_t t;
    t.we = we; t.wa = wa; t.wd = wd; t.me = me; t.ma = ma;
    t.rq = rq; t.r1 = r1; t.r2 = r2;
    t.ev = ev; t.eb = eb; t.e1 = e1; t.e2 = e2;
    return t;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(string tag, vec_t t);
    exp_t e;
    rd_wr_en    = t.we;
    reg_wr_addr = t.wa;
    reg_wr_data = t.wd;
    mark_en     = t.me;
    mark_addr   = t.ma;
    rd_req      = t.rq;
    rs1_addr    = t.r1;
    rs2_addr    = t.r2;
    if (t.ev) begin
      e.d1 = t.e1;
      e.d2 = t.e2;
      expq.push_back(e);
    end
    @(posedge clk);
    #1;
    chk({tag, " rd_valid"}, {31'd0, rd_valid}, {31'd0, t.ev});
    chk({tag, " rd_busy"}, {31'd0, rd_busy}, {31'd0, t.eb});
    if (rd_valid) begin
      if (expq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s unexpected: rd_valid with rs1=%h rs2=%h, none expected", tag, rs1_data, rs2_data);
      end else begin
        e = expq.pop_front();
        chk({tag, " rs1_data"}, rs1_data, e.d1);
        chk({tag, " rs2_data"}, rs2_data, e.d2);
        last1 = e.d1;
        last2 = e.d2;
      end
    end else begin
      if (t.ev && expq.size() != 0) void'(expq.pop_front());
      chk({tag, " rs1_hold"}, rs1_data, last1);
      chk({tag, " rs2_hold"}, rs2_data, last2);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    rd_wr_en = 1'b0; reg_wr_addr = '0; reg_wr_data = '0;
    mark_en = 1'b0; mark_addr = '0; rd_req = 1'b0; rs1_addr = '0; rs2_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset rd_busy", {31'd0, rd_busy}, 32'd0);
    chk("reset rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("reset rs1_data", rs1_data, 32'd0);
    chk("reset rs2_data", rs2_data, 32'd0);
    reset = 1'b0;

    //             we  wa     wd            me  ma     rq  r1     r2     ev  eb  e1            e2
    vecs.push_back(v(0, 5'd0,  32'h0,        0, 5'd0,  1, 5'd3,  5'd0,  1, 0, 32'h0,        32'h0));
    vecs.push_back(v(1, 5'd5,  32'hDEADBEEF, 0, 5'd0,  0, 5'd0,  5'd0,  0, 0, 32'h0,        32'h0));
    vecs.push_back(v(0, 5'd0,  32'h0,        0, 5'd0,  1, 5'd5,  5'd5,  1, 0, 32'hDEADBEEF, 32'hDEADBEEF));
    vecs.push_back(v(1, 5'd0,  32'h1234,     0, 5'd0,  0, 5'd0,  5'd0,  0, 0, 32'h0,        32'h0));
    vecs.push_back(v(0, 5'd0,  32'h0,        0, 5'd0,  1, 5'd0,  5'd5,  1, 0, 32'h0,        32'hDEADBEEF));
    vecs.push_back(v(0, 5'd0,  32'h0,        1, 5'd7,  0, 5'd0,  5'd0,  0, 0, 32'h0,        32'h0));
    vecs.push_back(v(0, 5'd0,  32'h0,        0, 5'd0,  0, 5'd0,  5'd0,  0, 0, 32'h0,        32'h0));
    vecs.push_back(v(0, 5'd0,  32'h0,        0, 5'd0,  1, 5'd7,  5'd0,  0, 1, 32'h0,        32'h0));
    vecs.push_back(v(0, 5'd0,  32'h0,        0, 5'd0,  1, 5'd7,  5'd0,  0, 1, 32'h0,        32'h0));
    vecs.push_back(v(0, 5'd0,  32'h0,        0, 5'd0,  1, 5'd7,  5'd0,  0, 1, 32'h0,        32'h0));
    vecs.push_back(v(1, 5'd7,  32'hA5A5A5A5, 0, 5'd0,  1, 5'd7,  5'd0,  1, 0, 32'hA5A5A5A5, 32'h0));
    vecs.push_back(v(0, 5'd0,  32'h0,        0, 5'd0,  0, 5'd0,  5'd0,  0, 0, 32'h0,        32'h0));
    vecs.push_back(v(0, 5'd0,  32'h0,        1, 5'd9,  0, 5'd0,  5'd0,  0, 0, 32'h0,        32'h0));
    vecs.push_back(v(1, 5'd9,  32'h55,       0, 5'd0,  1, 5'd9,  5'd5,  1, 0, 32'h55,       32'hDEADBEEF));
    vecs.push_back(v(1, 5'd4,  32'h77,       1, 5'd4,  0, 5'd0,  5'd0,  0, 0, 32'h0,        32'h0));
    vecs.push_back(v(0, 5'd0,  32'h0,        0, 5'd0,  1, 5'd4,  5'd0,  0, 1, 32'h0,        32'h0));
    vecs.push_back(v(0, 5'd0,  32'h0,        0, 5'd0,  0, 5'd0,  5'd0,  0, 1, 32'h0,        32'h0));
    vecs.push_back(v(1, 5'd4,  32'h88,       0, 5'd0,  0, 5'd0,  5'd0,  1, 0, 32'h88,       32'h0));
    vecs.push_back(v(0, 5'd0,  32'h0,        0, 5'd0,  1, 5'd5,  5'd9,  1, 0, 32'hDEADBEEF, 32'h55));
    vecs.push_back(v(0, 5'd0,  32'h0,        0, 5'd0,  1, 5'd7,  5'd4,  1, 0, 32'hA5A5A5A5, 32'h88));
    vecs.push_back(v(0, 5'd0,  32'h0,        0, 5'd0,  1, 5'd9,  5'd9,  1, 0, 32'h55,       32'h55));
    vecs.push_back(v(0, 5'd0,  32'h0,        1, 5'd5,  1, 5'd5,  5'd0,  1, 0, 32'hDEADBEEF, 32'h0));
    vecs.push_back(v(0, 5'd0,  32'h0,        0, 5'd0,  1, 5'd5,  5'd0,  0, 1, 32'h0,        32'h0));
    vecs.push_back(v(1, 5'd5,  32'h1,        0, 5'd0,  0, 5'd0,  5'd0,  1, 0, 32'h1,        32'h0));
    vecs.push_back(v(0, 5'd0,  32'h0,        1, 5'd10, 0, 5'd0,  5'd0,  0, 0, 32'h0,        32'h0));
    vecs.push_back(v(0, 5'd0,  32'h0,        1, 5'd11, 0, 5'd0,  5'd0,  0, 0, 32'h0,        32'h0));
    vecs.push_back(v(0, 5'd0,  32'h0,        0, 5'd0,  1, 5'd10, 5'd11, 0, 1, 32'h0,        32'h0));
    vecs.push_back(v(1, 5'd10, 32'hA,        0, 5'd0,  0, 5'd0,  5'd0,  0, 1, 32'h0,        32'h0));
    vecs.push_back(v(1, 5'd11, 32'hB,        0, 5'd0,  0, 5'd0,  5'd0,  1, 0, 32'hA,        32'hB));
    vecs.push_back(v(0, 5'd0,  32'h0,        1, 5'd0,  1, 5'd0,  5'd0,  1, 0, 32'h0,        32'h0));
    vecs.push_back(v(0, 5'd0,  32'h0,        0, 5'd0,  1, 5'd0,  5'd3,  1, 0, 32'h0,        32'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      apply($sformatf("v%0d", i), vecs[i]);
    end

    // Reset while a request is held in WAIT.
    apply("r0", v(0, 5'd0, 32'h0, 1, 5'd12, 0, 5'd0, 5'd0, 0, 0, 32'h0, 32'h0));
    apply("r1", v(0, 5'd0, 32'h0, 0, 5'd0,  1, 5'd12, 5'd0, 0, 1, 32'h0, 32'h0));
    rd_req = 1'b0;
    reset  = 1'b1;
    #1;
    chk("rst_wait rd_busy", {31'd0, rd_busy}, 32'd0);
    chk("rst_wait rd_valid", {31'd0, rd_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_wait rd_valid2", {31'd0, rd_valid}, 32'd0);
    reset = 1'b0;
    last1 = '0;
    last2 = '0;
    apply("r2", v(0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd0,  5'd0, 0, 0, 32'h0, 32'h0));
    apply("r3", v(0, 5'd0, 32'h0, 0, 5'd0, 1, 5'd7,  5'd5, 1, 0, 32'h0, 32'h0));
    apply("r4", v(0, 5'd0, 32'h0, 0, 5'd0, 1, 5'd12, 5'd4, 1, 0, 32'h0, 32'h0));
    apply("r5", v(0, 5'd0, 32'h0, 0, 5'd0, 1, 5'd9,  5'd11, 1, 0, 32'h0, 32'h0));
    apply("r6", v(0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd0,  5'd0, 0, 0, 32'h0, 32'h0));

    chk("queue drained", expq.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Architectural integer register file: the consumer end of the writeback write port, and the operand supplier for the issue stage. It holds NUM_REGS x XLEN registers with x0 hardwired to zero. A per-register pending scoreboard holds operand reads until in-flight results land. It sits between issue/decode (reservations, operand requests) and the writeback unit (register writes).

Parameters:
XLEN, 32, data width of each register
NUM_REGS, 32, number of architectural registers (power of two)
ADDR_W, 5, register address width, equal to log2(NUM_REGS)

Ports:
clk  input  1  single clock; all state updates on posedge
reset  input  1  asynchronous, active-high reset
rd_wr_en  input  1  writeback write strobe, one write per cycle
reg_wr_addr  input  ADDR_W  writeback destination register
reg_wr_data  input  XLEN  writeback data
mark_en  input  1  issue reserves a destination register (sets its pending bit)
mark_addr  input  ADDR_W  register being reserved
rd_req  input  1  operand read request; accepted only when rd_busy=0
rs1_addr  input  ADDR_W  source 1 address
rs2_addr  input  ADDR_W  source 2 address
rd_busy  output  1  a request is held waiting on pending sources; new requests are ignored
rd_valid  output  1  one-cycle pulse; rs1_data and rs2_data are valid
rs1_data  output  XLEN  source 1 operand
rs2_data  output  XLEN  source 2 operand

Behaviour:
- Reset (async, active-high): all registers 0, all pending bits 0, FSM IDLE, rd_busy=0, rd_valid=0, rs1_data=rs2_data=0. Asserting reset mid-WAIT abandons the held request; no rd_valid is produced.
- Write: rd_wr_en=1 with reg_wr_addr!=0 updates the register at the posedge and clears its pending bit. Writes to x0 are dropped. Reads of x0 always return 0 and x0 is never pending.
- Mark: mark_en=1 with mark_addr!=0 sets the pending bit at the posedge. If mark and write hit the same address in the same cycle, the data is written and the pending bit ends up SET: the new reservation wins.
- Effective pending in a cycle = pending bit AND NOT (write to the same address this cycle). Same-cycle marks are not included; the requester is older than the instruction being marked.
- FSM states: IDLE and WAIT.
  - IDLE: on rd_req=1, latch rs1_addr and rs2_addr.
    - If neither source is effectively pending, next cycle rd_valid=1 with data. Data is bypassed: a same-cycle write to a source address supplies reg_wr_data instead of the stored value. Stay in IDLE.
    - Otherwise go to WAIT, with rd_busy=1 from the next cycle.
  - WAIT: each cycle, re-evaluate effective pending for the latched addresses. When both are clear, rd_valid=1 next cycle with bypassed data, rd_busy=0 in that same cycle, and return to IDLE.
- Read latency: 1 cycle from accepted rd_req (or from the clearing write) to rd_valid.
- Back-to-back requests in IDLE: one rd_valid per cycle.
- rd_valid is 0 in every cycle that has no completion. rs1_data and rs2_data hold their last values.
- rd_req while rd_busy=1 is ignored. The requester must hold the request and retry.
- The same source in rs1 and rs2 is allowed; both outputs carry the same value.

Decomposition:
- Shared package: XLEN, NUM_REGS, ADDR_W constants; a reg_addr_t typedef; a word_t typedef; an enum for the IDLE/WAIT state.
- Sub-module: regfile_bypass_read (combinational, one instance per source). Inputs: stored value, address, and write port. Output: the bypassed word, forced to 0 for x0.
- The FSM and scoreboard live in the top module.

Test Plan:
- Reset, then rd_req rs1=3, rs2=0 -> next cycle rd_valid=1, rs1_data=0, rs2_data=0, rd_busy=0.
- Write x5=0xDEADBEEF; next cycle rd_req rs1=5, rs2=5 -> rd_valid next cycle with both data=0xDEADBEEF. Write x0=0x1234, then read x0 -> 0.
- mark x7; 2 cycles later rd_req rs1=7 -> rd_busy=1 and no rd_valid. Write x7=0xA5A5A5A5 3 cycles later -> next cycle rd_valid=1, rs1_data=0xA5A5A5A5, rd_busy=0.
- x9 pending; rd_req rs1=9 in the same cycle as write x9=0x55 -> no WAIT, next cycle rd_valid=1 with rs1_data=0x55 (bypass).
- mark x4 and write x4=0x77 in the same cycle -> stored value 0x77, x4 still pending. A later read of x4 waits for the next write.
- rd_req on a pending source, then assert reset 1 cycle later -> rd_busy=0, rd_valid never pulses, all registers read 0 afterwards.
